scan_test_sequencer: RTL and testbench
======================================

# scan_test_sequencer

Scan-test sequencer for the scan-chained FSM core. It takes test patterns over a valid/ready handshake and drives the core's `scan_enable`, `scan_in` and `inp` through three phases: shift-in, one capture cycle, and shift-out. While the next pattern shifts in, it unloads the previous capture and compares it against the expected state and output. It sits between the ATPG pattern source and the core, and accumulates pass/fail statistics for fault-coverage runs.

## Interface
- `CHAIN_LEN`, default 3: number of scan flops in the core's chain (≥ 2).
- `CNT_W`, default 16: width of the pattern, fail and index counters.

- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pat_valid`  in  1: pattern-source handshake valid.
- `pat_ready`  out  1: the controller accepts a pattern this cycle.
- `pat_load`  in  CHAIN_LEN: state to load into the chain; bit 0 is shifted first.
- `pat_inp`  in  1: value of the core's `inp` during capture.
- `exp_state`  in  CHAIN_LEN: expected captured chain contents.
- `exp_out`  in  1: expected core `out` in the capture cycle.
- `dut_scan_enable`  out  1: drives the core's `scan_enable`.
- `dut_scan_in`  out  1: drives the core's `scan_in`.
- `dut_inp`  out  1: drives the core's `inp`.
- `dut_scan_out`  in  1: chain tail (bit 0) of the core.
- `dut_out`  in  1: the core's `out`.
- `busy`  out  1: high in any state other than IDLE.
- `result_valid`  out  1: one-cycle pulse when a comparison completes.
- `result_fail`  out  1: comparison failed; meaningful only while `result_valid` is high.
- `result_index`  out  CNT_W: 0-based ordinal of the compared pattern.
- `pat_count`  out  CNT_W: number of accepted patterns.
- `fail_count`  out  CNT_W: number of failing comparisons.
- `done`  out  1: one-cycle pulse at the end of a pattern stream.

## Operation
- Chain convention:
  - `scan_in` feeds bit CHAIN_LEN-1 and bit 0 feeds `scan_out`.
  - The first bit shifted in lands at bit 0, and captured bit 0 is the first bit shifted out.
- States: IDLE, SHIFT, CAPTURE, UNLOAD.
- IDLE:
  - `pat_ready`=1, `dut_scan_enable`=0, `dut_scan_in`=0, `dut_inp`=0.
  - On `pat_valid` && `pat_ready`: latch `pat_load`, `pat_inp`, `exp_state` and `exp_out`; increment `pat_count`; go to SHIFT with no pending response.
- SHIFT, CHAIN_LEN cycles, k = 0..CHAIN_LEN-1:
  - `dut_scan_enable`=1, `dut_scan_in`=`pat_load[k]`.
  - At the edge ending cycle k, shift `dut_scan_out` into response bit k.
  - After cycle CHAIN_LEN-1, go to CAPTURE.
- CAPTURE, 1 cycle:
  - `dut_scan_enable`=0, `dut_inp`=`pat_inp`.
  - Sample `dut_out` at the edge and record `out_err` = (`dut_out` != `exp_out`).
  - `pat_ready`=1 in this cycle.
  - If a pattern is accepted: latch it, move the current expectations and `out_err` to the pending slot, and go to SHIFT with a pending response.
  - Otherwise go to UNLOAD.
- UNLOAD, CHAIN_LEN cycles: `dut_scan_enable`=1, `dut_scan_in`=0, and responses are collected as in SHIFT; then go to IDLE.
- Compare, at the end of a SHIFT with a pending response or at the end of UNLOAD:
  - fail = (response != pending `exp_state`) || pending `out_err`.
  - `result_valid` pulses with `result_fail`=fail and `result_index`=pending ordinal.
  - `fail_count` increments on fail.
- `done` pulses together with the UNLOAD result.
- `pat_ready` is 0 in SHIFT and UNLOAD.
- Arithmetic and width rules:
  - `pat_count` and `fail_count` saturate at all-ones.
  - `result_index` wraps modulo 2^CNT_W.
  - The shift counter is ceil(log2(CHAIN_LEN)) bits and never exceeds CHAIN_LEN-1.
- Boundary conditions:
  - `pat_valid` is ignored in SHIFT and UNLOAD.
  - A pattern offered in the same cycle as a UNLOAD compare waits for IDLE.
  - A stream of one pattern produces exactly one result and one `done`.

## Timing
- Reset (asynchronous, immediate, also mid-operation):
  - State returns to IDLE and every output goes to 0, except `pat_ready`=1 once `rst` deasserts.
  - All counters clear and the pending slot is discarded; no result is emitted.
- All outputs are registered, or decoded from registered state only. No combinational path runs from `dut_*` inputs to outputs.
- Pattern accepted in IDLE at edge T:
  - SHIFT occupies cycles T+1..T+CHAIN_LEN.
  - CAPTURE is cycle T+CHAIN_LEN+1.
- Back-to-back patterns: the accept-to-accept period is CHAIN_LEN+1 cycles.
- Result timing:
  - Result for pattern n (not the last) appears in the cycle after the final SHIFT cycle of pattern n+1, which coincides with the next CAPTURE.
  - Result for the last pattern appears CHAIN_LEN+1 cycles after its CAPTURE, in IDLE.
- `fail_count` reflects a result in the same cycle that `result_valid` is high.

## Test plan
Bench: behavioural 3-flop scan model with CHAIN_LEN=3, loopback `out` = XOR of the chain.
- Reset mid-SHIFT:
  - All outputs are 0 immediately; counts are 0.
  - After release, `pat_ready`=1 and no `result_valid` occurs.
- Single pattern, `pat_load`=3'b101, `pat_inp`=1, correct `exp_*`:
  - `dut_scan_in` sequence is 1,0,1 with enable high; one capture cycle with `dut_inp`=1; three unload cycles with `dut_scan_in`=0.
  - `result_valid` with fail=0 and index 0; `done`; `pat_count`=1.
- Two back-to-back patterns (3'b101, 3'b010):
  - Accepts are 4 cycles apart.
  - Result index 0 appears in the second CAPTURE cycle and index 1 after UNLOAD.
  - `fail_count`=0.
- Chain bit 1 stuck-at-0 in the model, pattern 3'b111: `result_fail`=1 and `fail_count`=1.
- Only `exp_out` wrong, state correct: `result_fail`=1 (out error path).
- `pat_valid` low at CAPTURE, then re-offered:
  - UNLOAD runs, `done` pulses, and the next pattern starts from IDLE with no extra result.

Source files
------------

// File: rtl/scan_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_sequencer_if
// Purpose  : Bundles the pattern-source handshake, the scan-core drive/observe
//            pins and the result/statistics outputs of scan_test_sequencer.
// Ports    : master - sequencer view (takes patterns and core pins, drives
//                     the core and reports results)
//            slave  - environment view (pattern source, scan core, monitor)
// Revision : 1.0 - initial release
// ============================================================================
interface scan_test_sequencer_if #(
   parameter int CHAIN_LEN = 3,
   parameter int CNT_W     = 16
);
   // Pattern source handshake
   logic                 pat_valid;
   logic                 pat_ready;
   logic [CHAIN_LEN-1:0] pat_load;
   logic                 pat_inp;
   logic [CHAIN_LEN-1:0] exp_state;
   logic                 exp_out;
   // Scan core pins
   logic                 dut_scan_enable;
   logic                 dut_scan_in;
   logic                 dut_inp;
   logic                 dut_scan_out;
   logic                 dut_out;
   // Status and results
   logic                 busy;
   logic                 result_valid;
   logic                 result_fail;
   logic [CNT_W-1:0]     result_index;
   logic [CNT_W-1:0]     pat_count;
   logic [CNT_W-1:0]     fail_count;
   logic                 done;

   modport master (
      input  pat_valid, pat_load, pat_inp, exp_state, exp_out,
      input  dut_scan_out, dut_out,
      output pat_ready, dut_scan_enable, dut_scan_in, dut_inp,
      output busy, result_valid, result_fail, result_index,
      output pat_count, fail_count, done
   );

   modport slave (
      output pat_valid, pat_load, pat_inp, exp_state, exp_out,
      output dut_scan_out, dut_out,
      input  pat_ready, dut_scan_enable, dut_scan_in, dut_inp,
      input  busy, result_valid, result_fail, result_index,
      input  pat_count, fail_count, done
   );
endinterface
`default_nettype wire

// File: rtl/scan_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_sequencer
// Purpose  : Drives a scan-chained FSM core through shift-in, capture and
//            shift-out. The previous capture is unloaded while the next
//            pattern shifts in, compared against its expectations, and
//            pass/fail statistics are accumulated.
// Ports    : clk - clock, rising edge
//            rst - asynchronous active-high reset
//            bus - scan_test_sequencer_if.master (handshake, core pins,
//                  results and counters)
// Revision : 1.0 - initial release
// ============================================================================
module scan_test_sequencer #(
   parameter int CHAIN_LEN = 3,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   scan_test_sequencer_if.master bus
);

   localparam int              CW         = $clog2(CHAIN_LEN);
   localparam logic [CW-1:0]   c_CNT_LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHIFT   = 2'd1,
      S_CAPTURE = 2'd2,
      S_UNLOAD  = 2'd3
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   // Pattern currently in flight
   logic [CHAIN_LEN-1:0] r_load;
   logic                 r_inp;
   logic [CHAIN_LEN-1:0] r_exp_state;
   logic                 r_exp_out;
   logic [CNT_W-1:0]     r_cur_index;
   logic [CNT_W-1:0]     r_next_index;
   // Captured pattern waiting for its response to be shifted out
   logic                 r_pend_valid;
   logic [CHAIN_LEN-1:0] r_pend_exp_state;
   logic                 r_pend_out_err;
   logic [CNT_W-1:0]     r_pend_index;
   logic [CHAIN_LEN-1:0] r_resp;
   // Registered outputs
   logic                 r_pat_ready;
   logic                 r_scan_enable;
   logic                 r_scan_in;
   logic                 r_dut_inp;
   logic                 r_busy;
   logic                 r_result_valid;
   logic                 r_result_fail;
   logic [CNT_W-1:0]     r_result_index;
   logic [CNT_W-1:0]     r_pat_count;
   logic [CNT_W-1:0]     r_fail_count;
   logic                 r_done;

   logic [CW-1:0]        w_cnt_inc;
   logic                 w_last;
   logic                 w_take;
   logic                 w_out_err;
   logic                 w_fail;
   logic [CHAIN_LEN-1:0] w_response;
   logic [CNT_W-1:0]     w_pat_count_inc;
   logic [CNT_W-1:0]     w_fail_count_inc;

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_last    = (r_cnt == c_CNT_LAST);
   // Ready is only ever high in IDLE and CAPTURE, so valid alone decides there
   assign w_take    = bus.pat_valid &&
                      ((r_state == S_IDLE) || (r_state == S_CAPTURE));
   assign w_out_err = (bus.dut_out != r_exp_out);

   // Response with the bit arriving this cycle merged in at position r_cnt,
   // so the final compare sees the complete word on the last shift edge.
   for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : g_resp
      assign w_response[gi] = (r_cnt == CW'(gi)) ? bus.dut_scan_out : r_resp[gi];
   end

   assign w_fail           = (w_response != r_pend_exp_state) || r_pend_out_err;
   assign w_pat_count_inc  = (r_pat_count  == '1) ? r_pat_count  : r_pat_count  + 1'b1;
   assign w_fail_count_inc = (r_fail_count == '1) ? r_fail_count : r_fail_count + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_load           <= '0;
         r_inp            <= 1'b0;
         r_exp_state      <= '0;
         r_exp_out        <= 1'b0;
         r_cur_index      <= '0;
         r_next_index     <= '0;
         r_pend_valid     <= 1'b0;
         r_pend_exp_state <= '0;
         r_pend_out_err   <= 1'b0;
         r_pend_index     <= '0;
         r_resp           <= '0;
         r_pat_ready      <= 1'b1;
         r_scan_enable    <= 1'b0;
         r_scan_in        <= 1'b0;
         r_dut_inp        <= 1'b0;
         r_busy           <= 1'b0;
         r_result_valid   <= 1'b0;
         r_result_fail    <= 1'b0;
         r_result_index   <= '0;
         r_pat_count      <= '0;
         r_fail_count     <= '0;
         r_done           <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         r_result_fail  <= 1'b0;
         r_done         <= 1'b0;

         if (w_take) begin
            r_load       <= bus.pat_load;
            r_inp        <= bus.pat_inp;
            r_exp_state  <= bus.exp_state;
            r_exp_out    <= bus.exp_out;
            r_cur_index  <= r_next_index;
            r_next_index <= r_next_index + 1'b1;
            r_pat_count  <= w_pat_count_inc;
         end

         case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_state       <= S_SHIFT;
                  r_cnt         <= '0;
                  r_pend_valid  <= 1'b0;
                  r_scan_enable <= 1'b1;
                  r_scan_in     <= bus.pat_load[0];
                  r_pat_ready   <= 1'b0;
                  r_busy        <= 1'b1;
               end
            end

            S_SHIFT: begin
               r_resp <= w_response;
               if (w_last) begin
                  r_state       <= S_CAPTURE;
                  r_cnt         <= '0;
                  r_scan_enable <= 1'b0;
                  r_scan_in     <= 1'b0;
                  r_dut_inp     <= r_inp;
                  r_pat_ready   <= 1'b1;
                  if (r_pend_valid) begin
                     r_result_valid <= 1'b1;
                     r_result_fail  <= w_fail;
                     r_result_index <= r_pend_index;
                     if (w_fail) r_fail_count <= w_fail_count_inc;
                  end
               end else begin
                  r_cnt     <= w_cnt_inc;
                  r_scan_in <= r_load[w_cnt_inc];
               end
            end

            S_CAPTURE: begin
               // The captured state is now in the chain; its expectations
               // travel with it until the response has been shifted out.
               r_pend_valid     <= 1'b1;
               r_pend_exp_state <= r_exp_state;
               r_pend_out_err   <= w_out_err;
               r_pend_index     <= r_cur_index;
               r_cnt            <= '0;
               r_dut_inp        <= 1'b0;
               r_scan_enable    <= 1'b1;
               r_pat_ready      <= 1'b0;
               if (w_take) begin
                  r_state   <= S_SHIFT;
                  r_scan_in <= bus.pat_load[0];
               end else begin
                  r_state   <= S_UNLOAD;
                  r_scan_in <= 1'b0;
               end
            end

            S_UNLOAD: begin
               r_resp <= w_response;
               if (w_last) begin
                  r_state        <= S_IDLE;
                  r_cnt          <= '0;
                  r_pend_valid   <= 1'b0;
                  r_scan_enable  <= 1'b0;
                  r_pat_ready    <= 1'b1;
                  r_busy         <= 1'b0;
                  r_result_valid <= 1'b1;
                  r_result_fail  <= w_fail;
                  r_result_index <= r_pend_index;
                  r_done         <= 1'b1;
                  if (w_fail) r_fail_count <= w_fail_count_inc;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Ready is held low while reset is asserted and rises as soon as it drops.
   assign bus.pat_ready       = r_pat_ready & ~rst;
   assign bus.dut_scan_enable = r_scan_enable;
   assign bus.dut_scan_in     = r_scan_in;
   assign bus.dut_inp         = r_dut_inp;
   assign bus.busy            = r_busy;
   assign bus.result_valid    = r_result_valid;
   assign bus.result_fail     = r_result_fail;
   assign bus.result_index    = r_result_index;
   assign bus.pat_count       = r_pat_count;
   assign bus.fail_count      = r_fail_count;
   assign bus.done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_test_sequencer
// Purpose  : Self-checking bench for scan_test_sequencer with a 3-flop
//            behavioural scan core (out = XOR of the chain) and a result
//            scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_test_sequencer;

   localparam int CL    = 3;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scan_test_sequencer_if #(.CHAIN_LEN(CL), .CNT_W(CNT_W)) bus ();

   scan_test_sequencer #(.CHAIN_LEN(CL), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // ---------------- behavioural scan core ----------------
   logic [2:0] chain = 3'b000;
   logic       stuck = 1'b0;
   logic [2:0] w_mask;
   assign w_mask = stuck ? 3'b101 : 3'b111;

   function automatic logic [2:0] core_ns(input logic [2:0] s, input logic i);
      return {s[0] ^ i, s[2], s[1]};
   endfunction

   always @(posedge clk) begin
      if (bus.dut_scan_enable) chain <= {bus.dut_scan_in, chain[2:1]} & w_mask;
      else                     chain <= core_ns(chain, bus.dut_inp) & w_mask;
   end
   assign bus.dut_scan_out = chain[0];
   assign bus.dut_out      = ^chain;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic fail;
      int   idx;
      int   acc;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, n_acc = 0, n_pushed = 0, n_res = 0, n_done = 0;
   int   exp_fc = 0, last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) n_done++;
         if (bus.done && !bus.result_valid) chk("done_without_result", bus.done, 0);
         if (bus.result_valid) begin
            n_res++;
            if (sbq.size() == 0) begin
               chk("unexpected_result", bus.result_valid, 0);
            end else begin
               e = sbq.pop_front();
               if (e.fail) exp_fc++;
               chk("result_fail",    bus.result_fail, e.fail);
               chk("result_index",   bus.result_index, e.idx);
               chk("result_latency", cyc, e.acc + 2 * CL + 1);
               chk("done_on_last",   bus.done, sbq.size() == 0);
               chk("fail_count",     bus.fail_count, exp_fc);
            end
         end
      end
   end

   // Offer a pattern from a negedge; returns at the negedge after acceptance.
   task automatic offer(input logic [2:0] ld, input logic inp, input logic [2:0] es,
                        input logic eo, input logic ef);
      bus.pat_load  = ld;
      bus.pat_inp   = inp;
      bus.exp_state = es;
      bus.exp_out   = eo;
      bus.pat_valid = 1'b1;
      for (int w = 0; w < 40; w++) begin
         if (bus.pat_ready) begin
            @(negedge clk);
            last_acc = cyc;
            sbq.push_back(exp_t'{ef, n_acc, cyc});
            n_acc++;
            n_pushed++;
            bus.pat_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("accept_timeout", bus.pat_ready, 1);
      bus.pat_valid = 1'b0;
   endtask

   // Offer a pattern with correct expectations unless a failure is wanted.
   task automatic offer_good(input logic [2:0] ld, input logic inp);
      offer(ld, inp, core_ns(ld, inp), ^ld, 1'b0);
   endtask

   task automatic wait_idle();
      for (int w = 0; w < 60; w++) begin
         if (!bus.busy && sbq.size() == 0) begin
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      chk("idle_timeout", bus.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] pv;
      int a0, res_snap;
      bus.pat_valid = 1'b0;
      bus.pat_load  = '0;
      bus.pat_inp   = 1'b0;
      bus.exp_state = '0;
      bus.exp_out   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pat_ready",   bus.pat_ready, 0);
      chk("rst_busy",        bus.busy, 0);
      chk("rst_scan_enable", bus.dut_scan_enable, 0);
      chk("rst_pat_count",   bus.pat_count, 0);
      chk("rst_result_valid", bus.result_valid, 0);
      rst = 1'b0;
      #1;
      chk("rel_pat_ready", bus.pat_ready, 1);
      @(negedge clk);

      // Single pattern 101, inp=1: pin sequence through all three phases
      pv = 3'b101;
      offer_good(pv, 1'b1);
      for (int k = 0; k < CL; k++) begin
         chk("shift_enable",  bus.dut_scan_enable, 1);
         chk("shift_scan_in", bus.dut_scan_in, pv[k]);
         @(negedge clk);
      end
      chk("cap_enable",    bus.dut_scan_enable, 0);
      chk("cap_inp",       bus.dut_inp, 1);
      chk("cap_pat_ready", bus.pat_ready, 1);
      @(negedge clk);
      for (int k = 0; k < CL; k++) begin
         chk("unload_enable",    bus.dut_scan_enable, 1);
         chk("unload_scan_in",   bus.dut_scan_in, 0);
         chk("unload_pat_ready", bus.pat_ready, 0);
         @(negedge clk);
      end
      wait_idle();
      chk("single_pat_count", bus.pat_count, 1);

      // Back-to-back 101, 010
      offer_good(3'b101, 1'b0);
      a0 = last_acc;
      offer_good(3'b010, 1'b1);
      chk("b2b_spacing", last_acc - a0, CL + 1);
      wait_idle();
      chk("b2b_fail_count", bus.fail_count, 0);
      chk("b2b_pat_count",  bus.pat_count, 3);

      // Chain bit 1 stuck-at-0
      stuck = 1'b1;
      @(negedge clk);
      offer(3'b111, 1'b1, core_ns(3'b111, 1'b1), ^3'b111, 1'b1);
      wait_idle();
      stuck = 1'b0;
      chk("stuck_fail_count", bus.fail_count, 1);

      // Only exp_out wrong
      offer(3'b011, 1'b0, core_ns(3'b011, 1'b0), ~(^3'b011), 1'b1);
      wait_idle();
      chk("outerr_fail_count", bus.fail_count, 2);

      // Valid low at CAPTURE, next pattern offered during UNLOAD waits for IDLE
      offer_good(3'b110, 1'b1);
      a0 = last_acc;
      repeat (5) @(negedge clk);
      offer_good(3'b001, 1'b0);
      chk("idle_restart_spacing", last_acc - a0, 2 * CL + 2);
      wait_idle();
      chk("restart_pat_count", bus.pat_count, 7);

      // Reset mid-SHIFT
      offer_good(3'b101, 1'b1);
      @(negedge clk);
      chk("midshift_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      n_pushed -= sbq.size();
      sbq.delete();
      n_acc  = 0;
      exp_fc = 0;
      res_snap = n_res;
      chk("midrst_busy",        bus.busy, 0);
      chk("midrst_scan_enable", bus.dut_scan_enable, 0);
      chk("midrst_pat_ready",   bus.pat_ready, 0);
      chk("midrst_pat_count",   bus.pat_count, 0);
      chk("midrst_fail_count",  bus.fail_count, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_rel_ready", bus.pat_ready, 1);
      repeat (12) @(negedge clk);
      chk("midrst_no_result", n_res, res_snap);

      // First pattern after reset restarts indices and counts
      offer_good(3'b010, 1'b0);
      wait_idle();
      chk("post_rst_pat_count", bus.pat_count, 1);

      chk("total_results", n_res, n_pushed);
      chk("total_done",    n_done, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
